// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per clock into an 11-entry buffer, streamed as written.
// Define AES_KSCHED_REVERSE_EN to read the buffer in decryption order (rd_idx 0 -> round key 10).

module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // GF(2^8) inverse as x^254 (maps 0 to 0), then the FIPS-197 affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] e;
      e   = 8'hfe;
      inv = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         inv = gmul(inv, inv);
         if (e[i]) inv = gmul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign dout = sbox(din);
endmodule

module aes_key_schedule (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         rk_valid,
   output logic [3:0]   rk_idx,
   output logic [127:0] rk_out,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);
   localparam int NUM_LANES = 4;
   localparam int NUM_RK    = 11;

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t       state;
   logic [3:0]   r;
   logic [7:0]   rcon;
   logic [127:0] kbuf [0:NUM_RK-1];

   logic [31:0]  rot_w, sub_w, temp;
   logic [31:0]  w0n, w1n, w2n, w3n;
   logic [127:0] next_rk;

   // rk_out always holds buffer[r-1] while expanding, so it feeds the next round directly
   assign rot_w = {rk_out[23:0], rk_out[31:24]};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_sub
      aes_sbox u_sbox (
         .din  (rot_w[g*8 +: 8]),
         .dout (sub_w[g*8 +: 8])
      );
   end

   assign temp    = sub_w ^ {rcon, 24'h0};
   assign w0n     = rk_out[127:96] ^ temp;
   assign w1n     = rk_out[95:64]  ^ w0n;
   assign w2n     = rk_out[63:32]  ^ w1n;
   assign w3n     = rk_out[31:0]   ^ w2n;
   assign next_rk = {w0n, w1n, w2n, w3n};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         r        <= 4'd0;
         rcon     <= 8'h01;
         busy     <= 1'b0;
         done     <= 1'b0;
         rk_valid <= 1'b0;
         rk_idx   <= 4'd0;
         rk_out   <= '0;
         for (int i = 0; i < NUM_RK; i++) kbuf[i] <= '0;
      end else begin
         rk_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  kbuf[0]  <= key_in;
                  rk_out   <= key_in;
                  rk_idx   <= 4'd0;
                  rk_valid <= 1'b1;
                  r        <= 4'd1;
                  rcon     <= 8'h01;
                  busy     <= 1'b1;
                  state    <= EXPAND;
               end
            end
            EXPAND: begin
               kbuf[r]  <= next_rk;
               rk_out   <= next_rk;
               rk_idx   <= r;
               rk_valid <= 1'b1;
               r        <= r + 4'd1;
               rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               if (r == 4'd10) begin
                  r     <= 4'd0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_key = '0;
      if (rd_idx <= 4'd10) begin
`ifdef AES_KSCHED_REVERSE_EN
         rd_key = kbuf[4'd10 - rd_idx];
`else
         rd_key = kbuf[rd_idx];
`endif
      end
   end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: vector table, corner sequences, random keys vs word-level model.

module tb_aes_key_schedule;
   logic         clk = 1'b0;
   logic         rst_n, start;
   logic [127:0] key_in;
   logic         busy, done, rk_valid;
   logic [3:0]   rk_idx, rd_idx;
   logic [127:0] rk_out, rd_key;

   int checks = 0;
   int errors = 0;

   typedef logic [127:0] keys_t [0:10];
   typedef struct {
      logic [127:0] key;
      logic [127:0] rk1;
      logic [127:0] rk10;
   } vec_t;

   keys_t exp_rk;
   keys_t got_rk;
   vec_t  tab [0:1];

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [79:0] RCON = 80'h01020408102040801b36;

   always #5 clk = ~clk;

   aes_key_schedule dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .done     (done),
      .rk_valid (rk_valid),
      .rk_idx   (rk_idx),
      .rk_out   (rk_out),
      .rd_idx   (rd_idx),
      .rd_key   (rd_key)
   );

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   function automatic logic [7:0] sb(input logic [7:0] x);
      return SBOX[2047 - 8*int'(x) -: 8];
   endfunction

   // FIPS-197 word recurrence over w[0..43]
   task automatic model(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0)
            t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^
                {RCON[79 - 8*(i/4 - 1) -: 8], 24'h0};
         w[i] = w[i-4] ^ t;
      end
      for (int k = 0; k < 11; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
   endtask

   function automatic logic [127:0] exp_read(input int i);
      if (i > 10) return '0;
`ifdef AES_KSCHED_REVERSE_EN
      return exp_rk[10 - i];
`else
      return exp_rk[i];
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Starts an expansion from the current (idle or done) cycle; inj = edge offset of a stray start
   task automatic run(input logic [127:0] key, input int inj, input string nm);
      model(key);
      key_in = key;
      start  = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         cyc();
         key_in = {$urandom, $urandom, $urandom, $urandom};
         start  = (c + 1 == inj);
         chk({nm, " rk_valid"}, 128'(rk_valid), 128'(1));
         chk({nm, " rk_idx"},   128'(rk_idx),   128'(c));
         chk({nm, " rk_out"},   rk_out,         exp_rk[c]);
         chk({nm, " busy"},     128'(busy),     128'(c < 10));
         chk({nm, " done"},     128'(done),     128'(c == 10));
         got_rk[c] = rk_out;
      end
      start = 1'b0;
   endtask

   task automatic read_all(input string nm);
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         chk({nm, " rd_key"}, rd_key, exp_read(i));
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      key_in = '0;
      rd_idx = 4'd0;
      tab[0] = '{FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605, FIPS_RK10};
      tab[1] = '{128'h0,   128'h62636363626363636263636362636363, ZERO_RK10};

      repeat (2) cyc();
      chk("rst busy",     128'(busy),     128'(0));
      chk("rst done",     128'(done),     128'(0));
      chk("rst rk_valid", 128'(rk_valid), 128'(0));
      chk("rst rk_idx",   128'(rk_idx),   128'(0));
      chk("rst rk_out",   rk_out,         128'(0));
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         chk("rst rd_key", rd_key, 128'(0));
      end
      rst_n = 1'b1;
      cyc();
      chk("idle busy", 128'(busy), 128'(0));

      for (int v = 0; v < 2; v++) begin
         run(tab[v].key, -1, "tab");
         chk("tab rk1",  got_rk[1],  tab[v].rk1);
         chk("tab rk10", got_rk[10], tab[v].rk10);
         read_all("tab");
         cyc();
         chk("tab done once", 128'(done), 128'(0));
      end

      rd_idx = 4'd12;
      #1;
      chk("rd_idx 12", rd_key, 128'(0));

      // stray start at E0+4 with a different key must be ignored
      run(FIPS_KEY, 4, "busy_ign");
      chk("busy_ign rk10", got_rk[10], FIPS_RK10);
      cyc();
      chk("busy_ign single done", 128'(done), 128'(0));
      chk("busy_ign idle", 128'(busy), 128'(0));
`ifdef AES_KSCHED_REVERSE_EN
      rd_idx = 4'd0;
`else
      rd_idx = 4'd10;
`endif
      #1;
      chk("rd last round", rd_key, FIPS_RK10);
      cyc();

      // back-to-back: second start lands in the done cycle
      run(FIPS_KEY, -1, "b2b_a");
      run(128'h0, -1, "b2b_b");
      chk("b2b rk10", got_rk[10], ZERO_RK10);
      read_all("b2b");
      cyc();

      // reset mid-run
      key_in = FIPS_KEY;
      start  = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      rst_n = 1'b0;
      #1;
      chk("abort busy",     128'(busy),     128'(0));
      chk("abort done",     128'(done),     128'(0));
      chk("abort rk_valid", 128'(rk_valid), 128'(0));
      chk("abort rk_out",   rk_out,         128'(0));
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         chk("abort rd_key", rd_key, 128'(0));
      end
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         cyc();
         chk("abort no done",  128'(done),     128'(0));
         chk("abort no valid", 128'(rk_valid), 128'(0));
      end

      for (int n = 0; n < 25; n++) begin
         run({$urandom, $urandom, $urandom, $urandom},
             ($urandom_range(1) == 1) ? int'($urandom_range(10, 1)) : -1, "rand");
         if ($urandom_range(1) == 0) begin
            read_all("rand");
            cyc();
            chk("rand idle", 128'(busy), 128'(0));
         end
      end
      repeat (2) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential AES-128 key expansion unit sitting directly upstream of the AES encrypt datapath. It takes the 128-bit cipher key and produces round keys 0..10, one per clock, into an internal 11-entry buffer. The encrypt rounds read that buffer through a combinational read port. Each round key is also streamed out as it is produced, together with a handshake that says when the whole schedule is valid.

## Interface
- No parameters. Key size is fixed at 128 bits and the round count at 10.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request expansion of `key_in`; sampled on the rising edge.
- `key_in`  in  128  — cipher key, FIPS-197 byte order (MSB = byte 0).
- `busy`  out  1  — expansion in progress.
- `done`  out  1  — one-cycle pulse: all 11 round keys are valid in the buffer.
- `rk_valid`  out  1  — one-cycle pulse: `rk_out`/`rk_idx` hold a newly written round key.
- `rk_idx`  out  4  — index (0..10) of the key on `rk_out`.
- `rk_out`  out  128  — newly written round key.
- `rd_idx`  in  4  — buffer read index.
- `rd_key`  out  128  — combinational read of buffer entry `rd_idx`.

## Operation
- FSM states:
  - IDLE: when `start` = 1, go to EXPAND.
  - EXPAND: stay while round counter r < 10; go to IDLE after writing round 10.
- Start edge (E0, IDLE with `start` = 1):
  - `key_in` is written to buffer[0] and presented on `rk_out` with `rk_idx` = 0, `rk_valid` = 1.
  - r is set to 1 and rcon to 0x01.
- Each EXPAND cycle computes one round key from buffer[r-1]:
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2' (w0 = bits 127:96).
- SubWord uses four instances of the codebase's existing S-box module.
- Per round: write buffer[r], drive `rk_out`/`rk_idx` = r with `rk_valid` = 1, then r ← r+1 and rcon ← xtime(rcon).
  - xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
  - Resulting sequence: 01 02 04 08 10 20 40 80 1b 36.
- `start` while EXPAND is ignored; the key being expanded is not disturbed.
- `key_in` is only sampled at E0; later changes have no effect.
- `rd_idx` 0..10 returns the entry; 11..15 return 0. The buffer holds its contents until the next start or reset.
- Buffer entries are overwritten progressively during a new expansion. The consumer must not read until `done`.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - state IDLE, r = 0, rcon = 0x01.
  - `busy`, `done`, `rk_valid` = 0; `rk_idx` = 0; `rk_out` = 0.
  - All buffer entries = 0, so `rd_key` = 0.
- Round key r is written at edge E0+r (r = 0..10). `rk_valid` is high in the cycle after each such edge.
- `busy` is high in the cycles following edges E0 .. E0+9 and low after E0+10.
- `done` is high exactly in the cycle following E0+10. Total latency from start to done is 11 cycles.
- `start` in the same cycle that `done` is high is accepted: the FSM is IDLE at that point.
- Reset asserted mid-expansion aborts immediately and clears everything. No `done` is produced for the aborted key.

## Configuration
- `AES_KSCHED_REVERSE_EN` defined:
  - `rd_key` returns buffer[10 − `rd_idx`] for `rd_idx` 0..10 (decryption ordering).
  - Out-of-range indices still return 0.
- Undefined: `rd_key` returns buffer[`rd_idx`] (encryption ordering).
- Streamed `rk_out` order is unaffected in both builds.

## Test plan
- FIPS-197 key expansion:
  - Stimulus: `key_in` = 2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - Response: `rk_out` with `rk_idx` 1 = a0fafe1788542cb123a339392a6c7605; with `rk_idx` 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` one cycle, 11 cycles after start.
- Zero key:
  - Stimulus: `key_in` = 0, start pulse.
  - Response: rd_key[1] = 62636363626363636263636362636363; rd_key[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start while busy:
  - Stimulus: second start with a different key at E0+4.
  - Response: ignored; round 10 still d014f9a8…; exactly one `done`.
- Back-to-back:
  - Stimulus: start asserted in the `done` cycle with the zero key.
  - Response: new expansion begins; second `done` after 11 more cycles with zero-key results.
- Reset mid-run:
  - Stimulus: `rst_n` low at E0+5.
  - Response: `busy`/`done`/`rk_valid` immediately 0; `rd_key` = 0 for all indices; no `done` after release.
- Read port:
  - Stimulus: `rd_idx` = 12.
  - Response: `rd_key` = 0.
  - With `AES_KSCHED_REVERSE_EN` defined and `rd_idx` = 0 after FIPS expansion: `rd_key` = d014f9a8c9ee2589e13f0cc8b6630ca6.
